// File: rtl/seq_alu.sv
// seq_alu: sequential ALU, in_valid/in_ready request (op1, op2, alu_mode, carry_select, flag_we) -> registered out_valid/result/ccr {c,n,z}; MUL by shift-add
module seq_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [2:0]       alu_mode,
  input  logic [1:0]       carry_select,
  input  logic             flag_we,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       ccr
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, MUL} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] a, b, acc, addend, res_c;
  logic [WIDTH:0] sum, diff;
  logic [2:0] mode;
  logic [1:0] cs;
  logic [CW-1:0] cnt;
  logic fwe, pend, fin, accept, last, alu_c, carry_n;
  always_comb begin
    in_ready = state == IDLE;
    accept = in_valid && in_ready;
    last = state == MUL && cnt == CW'(WIDTH - 2);
    state_nxt = accept && alu_mode == 3'd7 ? MUL : last ? IDLE : state;
  end
  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    addend = b[0] ? a : '0;
    res_c = mode == 3'd0 ? sum[WIDTH-1:0] :
            mode == 3'd1 ? ~a :
            mode == 3'd2 ? a :
            mode == 3'd3 ? '0 :
            mode == 3'd4 ? diff[WIDTH-1:0] :
            mode == 3'd5 ? a & b :
            mode == 3'd6 ? a | b : acc + addend;
    alu_c = mode == 3'd0 ? sum[WIDTH] : mode == 3'd4 ? diff[WIDTH] : 1'b0;
    carry_n = cs == 2'd0 ? 1'b0 : cs == 2'd1 ? 1'b1 : cs == 2'd2 ? alu_c : ccr[2];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      pend <= 1'b0;
      fin <= 1'b0;
      out_valid <= 1'b0;
      result <= '0;
      ccr <= '0;
      a <= '0;
      b <= '0;
      acc <= '0;
      mode <= '0;
      cs <= '0;
      fwe <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      pend <= accept && alu_mode != 3'd7;
      fin <= last;
      out_valid <= pend || fin;
      if (pend || fin) begin
        result <= res_c;
        if (fwe) ccr <= {carry_n, res_c[WIDTH-1], res_c == '0};
      end
      if (accept) begin
        a <= op1;
        b <= op2;
        acc <= '0;
        mode <= alu_mode;
        cs <= carry_select;
        fwe <= flag_we;
        cnt <= '0;
      end else if (state == MUL) begin
        acc <= acc + addend;
        a <= a << 1;
        b <= b >> 1;
        cnt <= cnt + 1'b1;
      end
    end
endmodule
